// File: rtl/univ_shift_reg.sv
// Universal shift register with an autonomous burst engine.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | MODE applied every enabled edge; START may launch a burst
// BURST | latched burst mode applied every enabled edge, cnt steps left
//
// A burst of COUNT steps takes the START edge plus COUNT enabled edges.
// DONE pulses on the edge of the final step, together with the final Q.
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             C,
    input  logic             RST_N,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic             SI,
    input  logic [WIDTH-1:0] D,
    input  logic             START,
    input  logic [CNT_W-1:0] COUNT,
    output logic [WIDTH-1:0] Q,
    output logic             SO_L,
    output logic             SO_R,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SHL   = 3'b001;
    localparam logic [2:0] M_SHR   = 3'b010;
    localparam logic [2:0] M_ROTL  = 3'b011;
    localparam logic [2:0] M_ROTR  = 3'b100;
    localparam logic [2:0] M_ASR   = 3'b101;
    localparam logic [2:0] M_LOAD  = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_bmode;
    logic [2:0]       w_bmode_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_start_shift;

    // One register update for a given operation; shared by IDLE and BURST.
    function automatic logic [WIDTH-1:0] apply_mode(input logic [2:0]       mode,
                                                    input logic [WIDTH-1:0] q,
                                                    input logic             si,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] res;
        res = q;
        case (mode)
            M_HOLD:  res = q;
            M_SHL:   res = {q[WIDTH-2:0], si};
            M_SHR:   res = {si, q[WIDTH-1:1]};
            M_ROTL:  res = {q[WIDTH-2:0], q[WIDTH-1]};
            M_ROTR:  res = {q[0], q[WIDTH-1:1]};
            M_ASR:   res = {q[WIDTH-1], q[WIDTH-1:1]};
            M_LOAD:  res = d;
            M_CLEAR: res = '0;
            default: res = q;
        endcase
        return res;
    endfunction

    // START only means something for the shift/rotate modes.
    assign w_start_shift = START && (MODE != M_HOLD) && (MODE != M_LOAD) && (MODE != M_CLEAR);

    // State, data, counter and DONE registers.
    always_ff @(posedge C or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_q     <= RESET_VAL;
            r_cnt   <= '0;
            r_bmode <= M_HOLD;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bmode <= w_bmode_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and datapath decode; DONE defaults low so it always self-clears.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_bmode_nxt = r_bmode;
        w_done_nxt  = 1'b0;
        if (EN) begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_shift) begin
                        if (COUNT == '0) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_bmode_nxt = MODE;
                            w_cnt_nxt   = COUNT;
                            w_state_nxt = S_BURST;
                        end
                    end else begin
                        w_q_nxt = apply_mode(MODE, r_q, SI, D);
                    end
                end
                S_BURST: begin
                    w_q_nxt   = apply_mode(r_bmode, r_q, SI, D);
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign Q    = r_q;
    assign SO_L = r_q[WIDTH-1];
    assign SO_R = r_q[0];
    assign BUSY = (r_state == S_BURST);
    assign DONE = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed literal results.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          C = 1'b0;
    logic          RST_N;
    logic          EN;
    logic [2:0]    MODE;
    logic          SI;
    logic [W-1:0]  D;
    logic          START;
    logic [CW-1:0] COUNT;
    logic [W-1:0]  Q;
    logic          SO_L, SO_R, BUSY, DONE;

    int total = 0;
    int bad   = 0;

    univ_shift_reg #(.WIDTH(W), .CNT_W(CW), .RESET_VAL('0)) dut (
        .C(C), .RST_N(RST_N), .EN(EN), .MODE(MODE), .SI(SI), .D(D),
        .START(START), .COUNT(COUNT), .Q(Q), .SO_L(SO_L), .SO_R(SO_R),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 C = ~C;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: register value as an integer 0..255, operations as arithmetic.
    function automatic int op_val(input int mode, input int q, input int si, input int d);
        int m;
        m = 2 ** W;
        case (mode)
            1: return (q * 2) % m + si;
            2: return q / 2 + si * (m / 2);
            3: return (q * 2) % m + q / (m / 2);
            4: return q / 2 + (q % 2) * (m / 2);
            5: return q / 2 + (q / (m / 2)) * (m / 2);
            6: return d;
            7: return 0;
            default: return q;
        endcase
    endfunction

    int m_q;
    int m_left;
    int m_bmode;
    bit m_busy;
    bit m_done;

    always @(posedge C or negedge RST_N) begin
        if (!RST_N) begin
            m_q = 0; m_left = 0; m_bmode = 0; m_busy = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (EN) begin
                if (m_busy) begin
                    m_q = op_val(m_bmode, m_q, int'(SI), int'(D));
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end else if (START && MODE >= 3'd1 && MODE <= 3'd5) begin
                    if (COUNT == 0) m_done = 1;
                    else begin
                        m_busy = 1; m_left = int'(COUNT); m_bmode = int'(MODE);
                    end
                end else begin
                    m_q = op_val(int'(MODE), m_q, int'(SI), int'(D));
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge C) begin
        chk("model_q",    int'(Q),    m_q);
        chk("model_busy", int'(BUSY), int'(m_busy));
        chk("model_done", int'(DONE), int'(m_done));
        chk("model_sol",  int'(SO_L), (m_q / (2 ** (W - 1))) % 2);
        chk("model_sor",  int'(SO_R), m_q % 2);
    end

    // Driver sits at a negedge; sets inputs, then waits one full cycle.
    task automatic op(input bit en, input int mode, input bit si, input int d,
                      input bit start, input int count);
        EN = en; MODE = 3'(mode); SI = si; D = W'(d); START = start; COUNT = CW'(count);
        @(negedge C);
    endtask

    initial begin
        RST_N = 1'b0; EN = 0; MODE = 0; SI = 0; D = 0; START = 0; COUNT = 0;
        @(negedge C); @(negedge C);
        RST_N = 1'b1;
        chk("reset_q", int'(Q), 8'h00);
        chk("reset_busy", int'(BUSY), 0);

        // Single-cycle modes.
        op(1, 6, 0, 8'hA5, 0, 0); chk("load_a5", int'(Q), 8'hA5);
        op(1, 1, 1, 0, 0, 0);     chk("shl_4b", int'(Q), 8'h4B);
        op(1, 2, 0, 0, 0, 0);     chk("shr_25", int'(Q), 8'h25);
        op(1, 6, 0, 8'h81, 0, 0);
        op(1, 3, 0, 0, 0, 0);     chk("rotl_03", int'(Q), 8'h03);
        op(1, 6, 0, 8'h81, 0, 0);
        op(1, 4, 0, 0, 0, 0);     chk("rotr_c0", int'(Q), 8'hC0);
        op(1, 6, 0, 8'h80, 0, 0);
        op(1, 5, 0, 0, 0, 0);     chk("asr_c0", int'(Q), 8'hC0);
        op(1, 0, 1, 8'hFF, 0, 0); chk("hold_c0", int'(Q), 8'hC0);
        op(0, 6, 0, 8'h11, 0, 0); chk("en0_hold", int'(Q), 8'hC0);
        op(1, 7, 0, 0, 0, 0);     chk("clear", int'(Q), 8'h00);
        op(1, 6, 0, 8'h3C, 1, 5); chk("start_load_q", int'(Q), 8'h3C);
        chk("start_load_busy", int'(BUSY), 0);

        // Burst rotl x3 from 01.
        op(1, 6, 0, 8'h01, 0, 0);
        op(1, 3, 0, 0, 1, 3);
        chk("b_start_q", int'(Q), 8'h01); chk("b_start_busy", int'(BUSY), 1);
        op(1, 7, 0, 8'hFF, 1, 9);
        chk("b_s1_q", int'(Q), 8'h02); chk("b_s1_busy", int'(BUSY), 1);
        op(1, 0, 1, 0, 0, 0);
        chk("b_s2_q", int'(Q), 8'h04); chk("b_s2_done", int'(DONE), 0);
        op(1, 0, 0, 0, 0, 0);
        chk("b_s3_q", int'(Q), 8'h08); chk("b_s3_done", int'(DONE), 1);
        chk("b_s3_busy", int'(BUSY), 0);
        op(1, 0, 0, 0, 0, 0);
        chk("b_done_clr", int'(DONE), 0); chk("b_after_q", int'(Q), 8'h08);

        // Same burst with EN low for two cycles after the first step.
        op(1, 6, 0, 8'h01, 0, 0);
        op(1, 3, 0, 0, 1, 3);
        op(1, 0, 0, 0, 0, 0); chk("e_s1_q", int'(Q), 8'h02);
        op(0, 0, 0, 0, 0, 0); chk("e_hold1_q", int'(Q), 8'h02);
        op(0, 0, 0, 0, 0, 0); chk("e_hold2_q", int'(Q), 8'h02);
        chk("e_hold2_busy", int'(BUSY), 1);
        op(1, 0, 0, 0, 0, 0); chk("e_s2_q", int'(Q), 8'h04);
        op(1, 0, 0, 0, 0, 0); chk("e_s3_q", int'(Q), 8'h08);
        chk("e_s3_done", int'(DONE), 1);
        op(0, 0, 0, 0, 0, 0); chk("e_done_clr_en0", int'(DONE), 0);
        op(1, 1, 1, 0, 1, 0);
        chk("z_done", int'(DONE), 1); chk("z_q", int'(Q), 8'h08);
        chk("z_busy", int'(BUSY), 0);
        op(1, 0, 0, 0, 0, 0); chk("z_done_clr", int'(DONE), 0);

        // Long shr burst flushes everything out to SI; asr burst keeps sign.
        op(1, 6, 0, 8'hFF, 0, 0);
        op(1, 2, 0, 0, 1, 10);
        for (int i = 0; i < 10; i++) op(1, 0, 0, 0, 0, 0);
        chk("flush_q", int'(Q), 8'h00); chk("flush_done", int'(DONE), 1);
        op(1, 6, 0, 8'h80, 0, 0);
        op(1, 5, 1, 0, 1, 2);
        op(1, 0, 0, 0, 0, 0);
        op(1, 0, 0, 0, 0, 0);
        chk("asr_burst_q", int'(Q), 8'hE0);
        op(1, 6, 0, 8'h00, 0, 0);
        op(1, 1, 1, 0, 1, 3);
        op(1, 0, 1, 0, 0, 0);
        op(1, 0, 0, 0, 0, 0);
        op(1, 0, 1, 0, 0, 0);
        chk("si_live_q", int'(Q), 8'h05);

        // Reset mid-cycle; then reset during burst step 2.
        op(1, 6, 0, 8'h5A, 0, 0);
        #2 RST_N = 1'b0;
        #1 chk("arst_q", int'(Q), 0); chk("arst_busy", int'(BUSY), 0);
        chk("arst_done", int'(DONE), 0);
        @(negedge C); RST_N = 1'b1;
        op(1, 6, 0, 8'h01, 0, 0);
        op(1, 3, 0, 0, 1, 3);
        op(1, 0, 0, 0, 0, 0); chk("r_s1_q", int'(Q), 8'h02);
        #2 RST_N = 1'b0;
        #1 chk("r_abort_q", int'(Q), 0); chk("r_abort_busy", int'(BUSY), 0);
        @(negedge C); RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op(1, 0, 0, 0, 0, 0);
            chk("r_no_done", int'(DONE), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
